imm_decode_stage: RTL and testbench



---
 rtl/imm_decode_stage.sv | 158 +++++++++++++++
 tb/tb_imm_decode_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - opcode classify + immediate generation feeding a two-entry skid buffer
// Immediate generator and decode-stage buffer controller for the ID/EX boundary.

module imm_operand_unit (
    input  logic [31:7] instr,
    input  logic [2:0]  imm_type,
    output logic [31:0] imm
);
    always_comb begin
        case (imm_type)
            3'd2:    imm = {{20{instr[31]}}, instr[31:20]};
            3'd3:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd4:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd5:    imm = {instr[31:12], 12'h000};
            3'd6:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 'x;
        endcase
    end
endmodule

module imm_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_type,
    output logic [31:0] out_pc,
    output logic        out_illegal,
    output logic [15:0] decoded_cnt,
    output logic [7:0]  illegal_cnt
);
    localparam logic [2:0] NOTYPE = 3'd0;
    localparam logic [2:0] RTYPE  = 3'd1;
    localparam logic [2:0] ITYPE  = 3'd2;
    localparam logic [2:0] STYPE  = 3'd3;
    localparam logic [2:0] BTYPE  = 3'd4;
    localparam logic [2:0] UTYPE  = 3'd5;
    localparam logic [2:0] JTYPE  = 3'd6;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t      state, state_next;
    logic [2:0]  dec_type;
    logic        dec_illegal;
    logic [31:0] gen_imm;
    logic [31:0] dec_imm;
    logic        push, pop;

    logic [31:0] sec_imm;
    logic [2:0]  sec_type;
    logic [31:0] sec_pc;
    logic        sec_illegal;

    always_comb begin
        dec_type    = NOTYPE;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_type = ITYPE;
            7'b0100011:                         dec_type = STYPE;
            7'b1100011:                         dec_type = BTYPE;
            7'b0110111, 7'b0010111:             dec_type = UTYPE;
            7'b1101111:                         dec_type = JTYPE;
            7'b0110011:                         dec_type = RTYPE;
            default:                            dec_illegal = 1'b1;
        endcase
    end

    imm_operand_unit u_imm (
        .instr    (in_instr[31:7]),
        .imm_type (dec_type),
        .imm      (gen_imm)
    );

    // Generator leaves types without an immediate undefined; pin them to zero.
    assign dec_imm = (dec_type == RTYPE || dec_type == NOTYPE) ? 32'h0 : gen_imm;

    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (!push && pop) state_next = EMPTY;
            end
            TWO:     if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm     <= 32'h0;
            out_type    <= NOTYPE;
            out_pc      <= 32'h0;
            out_illegal <= 1'b0;
            sec_imm     <= 32'h0;
            sec_type    <= NOTYPE;
            sec_pc      <= 32'h0;
            sec_illegal <= 1'b0;
            decoded_cnt <= 16'h0;
            illegal_cnt <= 8'h0;
        end else begin
            if (!flush) begin
                case (state)
                    EMPTY, ONE: begin
                        // In ONE a simultaneous pop frees the head, so the new entry lands there.
                        if (push && (state == EMPTY || pop)) begin
                            out_imm     <= dec_imm;
                            out_type    <= dec_type;
                            out_pc      <= in_pc;
                            out_illegal <= dec_illegal;
                        end else if (push) begin
                            sec_imm     <= dec_imm;
                            sec_type    <= dec_type;
                            sec_pc      <= in_pc;
                            sec_illegal <= dec_illegal;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            out_imm     <= sec_imm;
                            out_type    <= sec_type;
                            out_pc      <= sec_pc;
                            out_illegal <= sec_illegal;
                        end
                    end
                    default: ;
                endcase
            end
            if (pop) begin
                decoded_cnt <= decoded_cnt + 16'd1;
                if (out_illegal && illegal_cnt != 8'hFF)
                    illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed bench with queue-based reference model for imm_decode_stage

module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [2:0]  out_type;
    logic [15:0] decoded_cnt;
    logic [7:0]  illegal_cnt;

    int tests = 0;
    int fails = 0;

    imm_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type),
        .out_pc(out_pc), .out_illegal(out_illegal),
        .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  t;
        logic [31:0] pc;
        logic        ill;
    } ent_t;

    ent_t q[$];
    bit   m_ready = 1'b1;
    int   m_dec = 0;
    int   m_ill = 0;
    bit   started = 1'b0;

    function automatic ent_t ref_entry(input logic [31:0] ins, input logic [31:0] pc);
        ent_t e;
        e.pc  = pc;
        e.ill = 1'b0;
        e.imm = 32'h0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin e.t = 3'd2; e.imm = 32'($signed(ins[31:20])); end
            7'h23: begin e.t = 3'd3; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin e.t = 3'd4; e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
            7'h37, 7'h17: begin e.t = 3'd5; e.imm = {ins[31:12], 12'h000}; end
            7'h6F: begin e.t = 3'd6; e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
            7'h33: e.t = 3'd1;
            default: begin e.t = 3'd0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit pop, push;
        if (rst) begin
            q.delete();
            m_ready = 1'b1;
            m_dec   = 0;
            m_ill   = 0;
            started = 1'b1;
        end else if (started) begin
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && m_ready && !flush;
            if (pop) begin
                m_dec = (m_dec + 1) % 65536;
                if (q[0].ill && m_ill < 255) m_ill++;
            end
            if (flush) q.delete();
            else begin
                if (pop) q.delete(0);
                if (push) q.push_back(ref_entry(in_instr, in_pc));
            end
            m_ready = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("model_in_ready", 32'(in_ready), 32'(m_ready));
            chk("model_decoded_cnt", 32'(decoded_cnt), 32'(m_dec));
            chk("model_illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
            if (q.size() > 0) begin
                chk("model_out_imm", out_imm, q[0].imm);
                chk("model_out_type", 32'(out_type), 32'(q[0].t));
                chk("model_out_pc", out_pc, q[0].pc);
                chk("model_out_illegal", 32'(out_illegal), 32'(q[0].ill));
            end
        end
    end

    // Holds the instruction on the bus until the stage takes it.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_imm"}, out_imm, 32'd0);
        chk({tag, "_out_type"}, 32'(out_type), 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
        chk({tag, "_decoded_cnt"}, 32'(decoded_cnt), 32'd0);
        chk({tag, "_illegal_cnt"}, 32'(illegal_cnt), 32'd0);
    endtask

    logic [31:0] mix [8] = '{32'hFFF00093, 32'h00112623, 32'h0080006F, 32'h00000517,
                             32'h002081B3, 32'h0040A103, 32'h000080E7, 32'hFE000EE3};

    initial begin
        ent_t e;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;

        e = ref_entry(32'h00112623, 32'h0);
        chk("pin_sw_imm", e.imm, 32'd12);
        e = ref_entry(32'h0080006F, 32'h0);
        chk("pin_jal_imm", e.imm, 32'd8);
        chk("pin_jal_type", 32'(e.t), 32'd6);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        out_ready = 1'b1;

        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_type", 32'(out_type), 32'd2);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_illegal", 32'(out_illegal), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("addi_decoded", 32'(decoded_cnt), 32'd1);

        in_valid = 1'b1; in_instr = 32'h12345037; in_pc = 32'h104;
        @(negedge clk);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_type", 32'(out_type), 32'd5);
        in_instr = 32'hFE000EE3; in_pc = 32'h108;
        @(negedge clk);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_type", 32'(out_type), 32'd4);
        in_valid = 1'b0;
        @(negedge clk);

        out_ready = 1'b0;
        fork
            begin
                send(32'h00100093, 32'h200);
                send(32'h00200113, 32'h204);
                send(32'h00300193, 32'h208);
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_head_pc", out_pc, 32'h200);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        chk("stall_decoded", 32'(decoded_cnt), 32'd6);

        for (int i = 0; i < 300; i++) send(32'h0, 32'h1000 + 32'(i * 4));
        repeat (3) @(negedge clk);
        chk("sat_illegal_cnt", 32'(illegal_cnt), 32'd255);
        chk("sat_decoded_cnt", 32'(decoded_cnt), 32'd306);

        out_ready = 1'b0;
        send(32'h00400213, 32'h300);
        send(32'h00500293, 32'h304);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h308;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_decoded", 32'(decoded_cnt), 32'd306);
        chk("flush_illegal", 32'(illegal_cnt), 32'd255);
        @(negedge clk);
        chk("flush_nothing_emerges", 32'(out_valid), 32'd0);

        send(32'h00700393, 32'h400);
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_pop_counts", 32'(decoded_cnt), 32'd307);

        fork
            for (int i = 0; i < 8; i++) send(mix[i], 32'h500 + 32'(i * 4));
            for (int k = 0; k < 20; k++) begin
                out_ready = (k % 3 != 0);
                @(negedge clk);
            end
        join
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mix_decoded", 32'(decoded_cnt), 32'd315);

        out_ready = 1'b0;
        send(32'h00800413, 32'h600);
        send(32'h00900493, 32'h604);
        out_ready = 1'b1; rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00A00513; in_pc = 32'h608;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_after_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
